// File: rtl/mop_writer_pkg.sv
// mop_writer_pkg: shared ALU control codes, WSY opcode and writer FSM encoding
package mop_writer_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [5:0] OP_WSY  = 6'h2b;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mop_state_t;
endpackage

// File: rtl/mop_fifo.sv
// mop_fifo: synchronous FIFO with wrapping pointers and registered occupancy count
module mop_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic push_ok, pop_ok;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full;
  assign pop_ok = pop && !empty;
  assign rdata = mem[rptr];
  always_ff @(posedge clk)
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      if (push_ok) mem[wptr] <= wdata;
      wptr <= wptr + AW'(push_ok);
      rptr <= rptr + AW'(pop_ok);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
endmodule

// File: rtl/mop_writer.sv
// mop_writer: buffers WSY memory ops and issues them one at a time on the write bus
module mop_writer
  import mop_writer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mop_en,
  input  logic [31:0] mop_addr,
  input  logic [31:0] mop_data,
  output logic        mop_stall,
  output logic        bus_wvalid,
  output logic [31:0] bus_waddr,
  output logic [31:0] bus_wdata,
  input  logic        bus_wready,
  input  logic        bus_bvalid,
  input  logic        bus_berr,
  output logic        mop_err,
  output logic        mop_busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  mop_state_t state, state_nx;
  logic [TW-1:0] timer;
  logic [63:0] head;
  logic empty, full, pop, timed_out;
  mop_fifo #(.DEPTH(DEPTH), .W(64)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (mop_en),
    .pop   (pop),
    .wdata ({mop_addr, mop_data}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );
  assign mop_stall = full;
  assign bus_wvalid = state == REQ;
  assign pop = bus_wvalid && bus_wready;
  assign mop_busy = !empty || state != IDLE;
  assign timed_out = timer == TW'(TIMEOUT - 1);
  always_comb
    state_nx = state == IDLE ? (empty ? IDLE : REQ) :
               state == REQ  ? (bus_wready ? RESP : REQ) :
               (bus_bvalid || timed_out) ? IDLE : RESP;
  always_ff @(posedge clk)
    if (!rstn) begin
      state <= IDLE;
      timer <= '0;
      bus_waddr <= '0;
      bus_wdata <= '0;
      mop_err <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= state == RESP ? timer + 1'b1 : '0;
      if (state == IDLE && !empty) {bus_waddr, bus_wdata} <= head;
      if (state == RESP && (bus_bvalid ? bus_berr : timed_out)) mop_err <= 1'b1;
    end
endmodule

// File: tb/tb_mop_writer.sv
// tb_mop_writer: vector table, directed corner sequences and randomized scoreboard run
module tb_mop_writer;
  localparam int DEPTH = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic mop_en = 1'b0;
  logic [31:0] mop_addr = '0;
  logic [31:0] mop_data = '0;
  logic bus_wready = 1'b0;
  logic bus_bvalid = 1'b0;
  logic bus_berr = 1'b0;
  logic mop_stall, bus_wvalid, mop_err, mop_busy;
  logic [31:0] bus_waddr, bus_wdata;
  int checks = 0;
  int failures = 0;
  mop_writer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mop_en     (mop_en),
    .mop_addr   (mop_addr),
    .mop_data   (mop_data),
    .mop_stall  (mop_stall),
    .bus_wvalid (bus_wvalid),
    .bus_waddr  (bus_waddr),
    .bus_wdata  (bus_wdata),
    .bus_wready (bus_wready),
    .bus_bvalid (bus_bvalid),
    .bus_berr   (bus_berr),
    .mop_err    (mop_err),
    .mop_busy   (mop_busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic rstn, en;
    logic [31:0] addr, data;
    logic wready, bvalid, berr;
    logic wvalid;
    logic [31:0] waddr, wdata;
    logic stall, busy, err;
  } vec_t;
  vec_t tbl [13];
  function automatic vec_t mk(logic r, logic e, logic [31:0] a, logic [31:0] d, logic wr,
                              logic bv, logic be, logic wv, logic [31:0] wa, logic [31:0] wd,
                              logic st, logic bu, logic er);
    vec_t v;
    v.rstn = r; v.en = e; v.addr = a; v.data = d; v.wready = wr; v.bvalid = bv; v.berr = be;
    v.wvalid = wv; v.waddr = wa; v.wdata = wd; v.stall = st; v.busy = bu; v.err = er;
    return v;
  endfunction
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic do_reset();
    rstn = 1'b0;
    mop_en = 1'b0;
    bus_wready = 1'b0;
    bus_bvalid = 1'b0;
    bus_berr = 1'b0;
    tick();
    rstn = 1'b1;
  endtask
  task automatic push(logic [31:0] a, logic [31:0] d);
    mop_en = 1'b1;
    mop_addr = a;
    mop_data = d;
    tick();
    mop_en = 1'b0;
  endtask
  task automatic wait_wvalid(string name);
    int n = 0;
    while (!bus_wvalid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(bus_wvalid), 64'd1);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] got [$];
    logic [63:0] q [$];
    int n, hs_cnt, acc_at, wv_cnt;
    bit outst, err_m, acc, hs;
    int age;
    tbl[0]  = mk(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    tbl[3]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, 1'b1, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
    tbl[10] = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    tbl[12] = mk(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rstn = tbl[i].rstn;
      mop_en = tbl[i].en;
      mop_addr = tbl[i].addr;
      mop_data = tbl[i].data;
      bus_wready = tbl[i].wready;
      bus_bvalid = tbl[i].bvalid;
      bus_berr = tbl[i].berr;
      tick();
      chk($sformatf("vec%0d_wvalid", i), 64'(bus_wvalid), 64'(tbl[i].wvalid));
      chk($sformatf("vec%0d_waddr", i), 64'(bus_waddr), 64'(tbl[i].waddr));
      chk($sformatf("vec%0d_wdata", i), 64'(bus_wdata), 64'(tbl[i].wdata));
      chk($sformatf("vec%0d_stall", i), 64'(mop_stall), 64'(tbl[i].stall));
      chk($sformatf("vec%0d_busy", i), 64'(mop_busy), 64'(tbl[i].busy));
      chk($sformatf("vec%0d_err", i), 64'(mop_err), 64'(tbl[i].err));
    end
    do_reset();
    for (int i = 0; i < 4; i++) push(32'hA000 + 32'(i), 32'hB000 + 32'(i));
    chk("bp_stall_full", 64'(mop_stall), 64'd1);
    mop_en = 1'b1;
    mop_addr = 32'hA004;
    mop_data = 32'hB004;
    tick();
    tick();
    chk("bp_stall_hold", 64'(mop_stall), 64'd1);
    bus_wready = 1'b1;
    bus_bvalid = 1'b1;
    got.delete();
    acc_at = -1;
    n = 0;
    while ((mop_busy || mop_en) && n < 100) begin
      if (bus_wvalid && bus_wready) got.push_back(bus_waddr);
      acc = mop_en && !mop_stall;
      if (acc) acc_at = got.size();
      tick();
      if (acc) mop_en = 1'b0;
      n++;
    end
    chk("bp_drain_done", 64'(mop_busy), 64'd0);
    chk("bp_accept_after_hs", 64'(acc_at), 64'd1);
    chk("bp_issue_count", 64'(got.size()), 64'd5);
    for (int i = 0; i < got.size(); i++) chk($sformatf("bp_order%0d", i), 64'(got[i]), 64'(32'hA000 + 32'(i)));
    do_reset();
    push(32'hC0DE_0000, 32'h1234_5678);
    wait_wvalid("held_wvalid_rise");
    for (int i = 0; i < 5; i++) begin
      chk("held_wvalid", 64'(bus_wvalid), 64'd1);
      chk("held_addr", 64'(bus_waddr), 64'h0000_0000_C0DE_0000);
      chk("held_data", 64'(bus_wdata), 64'h0000_0000_1234_5678);
      tick();
    end
    bus_wready = 1'b1;
    bus_bvalid = 1'b1;
    hs_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus_wvalid && bus_wready) hs_cnt++;
      tick();
    end
    chk("held_handshakes", 64'(hs_cnt), 64'd1);
    do_reset();
    push(32'h0000_2004, 32'h0BAD_0BAD);
    bus_wready = 1'b1;
    wait_wvalid("to_wvalid_rise");
    tick();
    bus_wready = 1'b0;
    n = 0;
    wv_cnt = 0;
    while (mop_busy && n < 100) begin
      if (bus_wvalid) wv_cnt++;
      tick();
      n++;
    end
    chk("to_cycles", 64'(n), 64'(TIMEOUT));
    chk("to_wvalid_in_resp", 64'(wv_cnt), 64'd0);
    chk("to_err", 64'(mop_err), 64'd1);
    push(32'h0000_3000, 32'h5555_AAAA);
    bus_wready = 1'b1;
    bus_bvalid = 1'b1;
    got.delete();
    for (int c = 0; c < 20; c++) begin
      if (bus_wvalid && bus_wready) got.push_back(bus_waddr);
      tick();
    end
    chk("err_next_count", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("err_next_addr", 64'(got[0]), 64'h3000);
    chk("err_sticky", 64'(mop_err), 64'd1);
    do_reset();
    bus_wready = 1'b1;
    push(32'h4000, 32'h1);
    push(32'h4004, 32'h2);
    push(32'h4008, 32'h3);
    chk("rst_pre_busy", 64'(mop_busy), 64'd1);
    chk("rst_pre_wvalid", 64'(bus_wvalid), 64'd0);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rst_wvalid", 64'(bus_wvalid), 64'd0);
    chk("rst_waddr", 64'(bus_waddr), 64'd0);
    chk("rst_wdata", 64'(bus_wdata), 64'd0);
    chk("rst_stall", 64'(mop_stall), 64'd0);
    chk("rst_busy", 64'(mop_busy), 64'd0);
    chk("rst_err", 64'(mop_err), 64'd0);
    wv_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus_wvalid || mop_busy) wv_cnt++;
      tick();
    end
    chk("rst_no_activity", 64'(wv_cnt), 64'd0);
    do_reset();
    q.delete();
    outst = 1'b0;
    err_m = 1'b0;
    age = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_stall", 64'(mop_stall), 64'(q.size() == DEPTH));
      chk("rnd_busy", 64'(mop_busy), 64'(q.size() != 0 || outst));
      chk("rnd_err", 64'(mop_err), 64'(err_m));
      if (bus_wvalid) begin
        chk("rnd_one_outstanding", 64'(outst || q.size() == 0), 64'd0);
        if (q.size() != 0) chk("rnd_wreq", {bus_waddr, bus_wdata}, q[0]);
      end
      mop_en = $urandom_range(0, 2) != 0;
      mop_addr = $urandom;
      mop_data = $urandom;
      bus_wready = 1'($urandom_range(0, 1));
      bus_bvalid = outst ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 15) == 0);
      bus_berr = $urandom_range(0, 3) == 0;
      acc = mop_en && q.size() < DEPTH;
      hs = bus_wvalid && bus_wready && q.size() != 0;
      if (outst) begin
        if (bus_bvalid) begin
          outst = 1'b0;
          if (bus_berr) err_m = 1'b1;
        end else if (age + 1 == TIMEOUT) begin
          outst = 1'b0;
          err_m = 1'b1;
        end else age++;
      end
      if (hs) begin
        void'(q.pop_front());
        outst = 1'b1;
        age = 0;
      end
      if (acc) q.push_back({mop_addr, mop_data});
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mop_writer.md
MOP_WRITER -- requirements
Module: mop_writer

Interface
REQ-001 SHALL have parameter DEPTH, 4, number of buffered memory-op (WSY) requests; power of two, at least 2.
REQ-002 SHALL have parameter TIMEOUT, 16, maximum number of cycles spent waiting for a bus response.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port mop_en  input  1  EX-stage memory-op request strobe (WSY operation).
REQ-006 SHALL have port mop_addr  input  32  request address (ALU primary result, op_A).
REQ-007 SHALL have port mop_data  input  32  request write data (ALU secondary result, op_B).
REQ-008 SHALL have port mop_stall  output  1  buffer full; the pipeline holds the EX stage.
REQ-009 SHALL have port bus_wvalid  output  1  write request valid.
REQ-010 SHALL have port bus_waddr  output  32  write address.
REQ-011 SHALL have port bus_wdata  output  32  write data.
REQ-012 SHALL have port bus_wready  input  1  bus accepts the request.
REQ-013 SHALL have port bus_bvalid  input  1  write response valid.
REQ-014 SHALL have port bus_berr  input  1  response error, qualified by bus_bvalid.
REQ-015 SHALL have port mop_err  output  1  sticky flag set by a bus error or a timeout.
REQ-016 SHALL have port mop_busy  output  1  buffer non-empty or FSM not in IDLE.

Function
REQ-017 SHALL push {mop_addr, mop_data} into the FIFO on any cycle with mop_en=1 and the FIFO not full.
- Push is accepted at the same edge.
REQ-018 SHALL ignore mop_en while full.
- Upstream holds the request while mop_stall=1.
REQ-019 SHALL drive mop_stall = (count == DEPTH), decoded from registered count with no combinational path from mop_en.
REQ-020 SHALL leave count unchanged on a simultaneous push and pop.
- Read and write pointers wrap modulo DEPTH.
REQ-021 SHALL implement the state machine IDLE, REQ, RESP.
REQ-022 SHALL transition IDLE -> REQ when the FIFO is non-empty.
- The head entry is loaded into the bus_waddr/bus_wdata registers.
- Minimum latency is 1 cycle from push to bus_wvalid=1.
REQ-023 SHALL hold bus_wvalid=1 in REQ with stable address and data until bus_wready=1, then go REQ -> RESP.
- The FIFO is popped at that edge.
REQ-024 SHALL, in RESP, reset the timeout counter on entry and increment it every cycle.
REQ-025 SHALL go RESP -> IDLE on bus_bvalid=1, setting mop_err if bus_berr=1.
REQ-026 SHALL go RESP -> IDLE when the counter reaches TIMEOUT-1 without bus_bvalid, setting mop_err.
- The request is not retried.
REQ-027 SHALL treat bus_bvalid in IDLE or REQ as spurious and ignore it.
REQ-028 SHALL allow at most one outstanding bus request.
- bus_wvalid=0 in IDLE and RESP.
REQ-029 SHALL keep mop_err at 1 until reset.

Reset
REQ-030 SHALL, on any edge with rstn=0, set:
- FSM to IDLE
- count, pointers and timeout counter to 0
- bus_wvalid=0, bus_waddr=0, bus_wdata=0
- mop_err=0, mop_stall=0, mop_busy=0
REQ-031 SHALL, on reset asserted mid-transaction, discard buffered and in-flight requests.
- bus_wvalid drops on the next edge; no response is awaited afterwards.

Structure
REQ-032 SHALL place the FSM state encoding (IDLE=2'd0, REQ=2'd1, RESP=2'd2) and the WSY opcode constant in the shared define header alongside the existing ALU control codes.
REQ-033 SHALL instantiate exactly one sub-module, mop_fifo (parameterised synchronous FIFO, 64-bit entries, DEPTH deep); the FSM and timeout counter stay in mop_writer.

Verification
REQ-034 SHALL cover a single write:
- Stimulus: mop_en pulse with addr=0x0000_1000, data=0xDEAD_BEEF; wready=1; bvalid after 2 cycles.
- Response: bus_wvalid=1 for 1 cycle with those values, mop_busy returns to 0, mop_err=0.
REQ-035 SHALL cover backpressure:
- Stimulus: 4 back-to-back pushes with wready=0.
- Response: mop_stall=1 after the 4th; a 5th request held upstream is accepted once the first handshake completes; issue order is preserved.
REQ-036 SHALL cover a held request:
- Stimulus: wready low for 5 cycles.
- Response: bus_waddr/bus_wdata stable across all 5 cycles; exactly one handshake.
REQ-037 SHALL cover a bus error:
- Stimulus: bvalid=1 with berr=1.
- Response: mop_err=1 and stays 1; the following queued write still issues.
REQ-038 SHALL cover a timeout:
- Stimulus: no bvalid.
- Response: return to IDLE exactly TIMEOUT cycles after the wready handshake; mop_err=1.
REQ-039 SHALL cover reset in RESP with 2 entries queued:
- Stimulus: rstn=0 for 1 cycle.
- Response: all outputs at reset values; no further bus_wvalid.
